// File: rtl/multi_frequency_counter_pkg.sv
// Shared constants for the multi-channel frequency counter:
// 7-segment glyphs (bit0=a .. bit6=g, active high) and hex decoder.
package freq_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/multi_frequency_counter_if.sv
// Pad inputs, control and result/display bundle of the
// multi-channel frequency counter.
interface multi_frequency_counter_if #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PERIOD_W = 12
) ();

    localparam int SEL_W = $clog2(NUM_CH) + 1;

    logic [NUM_CH-1:0]       signal;
    logic                    period_load;
    logic [PERIOD_W-1:0]     period;
    logic                    both_edges;
    logic [SEL_W-1:0]        ch_sel;
    logic [NUM_CH*CNT_W-1:0] count_flat;
    logic [NUM_CH-1:0]       overflow;
    logic                    result_valid;
    logic [6:0]              segments;
    logic                    digit;

    modport master (
        output signal, period_load, period, both_edges, ch_sel,
        input  count_flat, overflow, result_valid, segments, digit
    );

    modport slave (
        input  signal, period_load, period, both_edges, ch_sel,
        output count_flat, overflow, result_valid, segments, digit
    );

endinterface

// File: rtl/multi_frequency_counter_channel.sv
// One measured channel: pad synchroniser, edge detect, saturating
// window counter and latched result/overflow.
module freq_channel #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_pin,
    input  logic             i_both_edges,
    input  logic             i_gate_end,
    input  logic             i_abort,
    output logic [CNT_W-1:0] o_result,
    output logic             o_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf_win;
    logic [CNT_W-1:0]       r_result;
    logic                   r_overflow;
    logic                   w_pin_s;
    logic                   w_edge;
    logic                   w_sat;
    logic [CNT_W-1:0]       w_cnt_inc;

    assign w_pin_s   = r_sync[SYNC_STAGES-1];
    assign w_edge    = i_both_edges ? (w_pin_s ^ r_hist)
                                    : (w_pin_s & ~r_hist);
    assign w_sat     = (r_cnt == CNT_MAX);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_hist <= w_pin_s;
        end
    end

    // Abort wins over gate end: a reloaded window never publishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_ovf_win  <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (i_abort) begin
            r_cnt     <= '0;
            r_ovf_win <= 1'b0;
        end else if (i_gate_end) begin
            r_result   <= (w_edge && !w_sat) ? w_cnt_inc : r_cnt;
            r_overflow <= r_ovf_win | (w_edge & w_sat);
            r_cnt      <= '0;
            r_ovf_win  <= 1'b0;
        end else if (w_edge) begin
            if (w_sat) begin
                r_ovf_win <= 1'b1;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/multi_frequency_counter.sv
// Multi-channel edge counter over a common loadable gate window,
// with a 2-digit multiplexed hex view of one selected channel.
module multi_frequency_counter #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int PERIOD_W       = 12,
    parameter int DEFAULT_PERIOD = 1200,
    parameter int SYNC_STAGES    = 2,
    parameter int DISP_DIV       = 10
) (
    input logic                      clk,
    input logic                      reset_n,
    multi_frequency_counter_if.slave bus
);

    import freq_pkg::*;

    localparam int SEL_W = $clog2(NUM_CH) + 1;
    localparam int EXT_W = (CNT_W > 8) ? CNT_W : 8;

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_gate_cnt;
    logic                r_valid;
    logic                w_load;
    logic                w_gate_end;
    logic [CNT_W-1:0]    w_result [NUM_CH];
    logic [NUM_CH-1:0]   w_ovf;

    logic [DISP_DIV-1:0] r_div;
    logic                r_digit;
    logic [6:0]          r_seg;
    logic                w_digit_nxt;
    logic [EXT_W-1:0]    w_ext;
    logic [7:0]          w_byte;
    logic [3:0]          w_nib;
    logic                w_sel_ok;
    logic [6:0]          w_seg_nxt;

    assign w_load     = bus.period_load && (bus.period != '0);
    assign w_gate_end = (r_gate_cnt == r_period - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period   <= PERIOD_W'(DEFAULT_PERIOD);
            r_gate_cnt <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_gate_end & ~w_load;
            if (w_load) begin
                r_period   <= bus.period;
                r_gate_cnt <= '0;
            end else if (w_gate_end) begin
                r_gate_cnt <= '0;
            end else begin
                r_gate_cnt <= r_gate_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        freq_channel #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .i_pin        (bus.signal[g]),
            .i_both_edges (bus.both_edges),
            .i_gate_end   (w_gate_end),
            .i_abort      (w_load),
            .o_result     (w_result[g]),
            .o_overflow   (w_ovf[g])
        );
        assign bus.count_flat[g*CNT_W +: CNT_W] = w_result[g];
    end

    assign bus.overflow     = w_ovf;
    assign bus.result_valid = r_valid;

    always_comb begin
        w_ext = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == SEL_W'(i)) begin
                w_ext = EXT_W'(w_result[i]);
            end
        end
    end

    // Segments follow the digit value being registered alongside them.
    assign w_byte      = w_ext[7:0];
    assign w_sel_ok    = (bus.ch_sel < SEL_W'(NUM_CH));
    assign w_digit_nxt = (&r_div) ? ~r_digit : r_digit;
    assign w_nib       = w_digit_nxt ? w_byte[7:4] : w_byte[3:0];
    assign w_seg_nxt   = w_sel_ok ? hex_to_seg(w_nib) : SEG_BLANK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_digit <= 1'b0;
            r_seg   <= SEG_0;
        end else begin
            r_div   <= r_div + 1'b1;
            r_digit <= w_digit_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign bus.segments = r_seg;
    assign bus.digit    = r_digit;

endmodule

// File: tb/tb_multi_frequency_counter.sv
// Self-checking bench: window-level reference model plus vector
// table and hand sequences for reload, display and reset.
module tb_multi_frequency_counter;

    localparam int NCH = 4;
    localparam int PW  = 12;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] sig = '0;
    logic           ld = 1'b0;
    logic [PW-1:0]  per = '0;
    logic           be = 1'b0;
    logic [2:0]     sel = '0;

    always #5 clk = ~clk;

    multi_frequency_counter_if #(.NUM_CH(4), .CNT_W(16), .PERIOD_W(12)) bus0 ();
    multi_frequency_counter_if #(.NUM_CH(2), .CNT_W(4),  .PERIOD_W(12)) bus4 ();

    assign bus0.signal      = sig;
    assign bus0.period_load = ld;
    assign bus0.period      = per;
    assign bus0.both_edges  = be;
    assign bus0.ch_sel      = sel;
    assign bus4.signal      = sig[1:0];
    assign bus4.period_load = ld;
    assign bus4.period      = per;
    assign bus4.both_edges  = be;
    assign bus4.ch_sel      = sel[1:0];

    multi_frequency_counter #(
        .NUM_CH(4), .CNT_W(16), .PERIOD_W(12), .DEFAULT_PERIOD(1200),
        .SYNC_STAGES(2), .DISP_DIV(4)
    ) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

    multi_frequency_counter #(
        .NUM_CH(2), .CNT_W(4), .PERIOD_W(12), .DEFAULT_PERIOD(1200),
        .SYNC_STAGES(2), .DISP_DIV(4)
    ) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Stimulus generator: 0 idle, 1 square on ch0, 2 random, 3 ch1 burst.
    int mode = 0;
    int half = 5;
    int sq = 0;
    int burst = 0;

    always @(negedge clk) begin
        case (mode)
            1: begin
                if (sq >= half - 1) begin
                    sig[0] = ~sig[0];
                    sq = 0;
                end else sq++;
            end
            2: for (int c = 0; c < NCH; c++)
                   if ($urandom_range(0, 3) == 0) sig[c] = ~sig[c];
            3: if (burst > 0) begin
                   sig[1] = ~sig[1];
                   burst--;
               end
            default: ;
        endcase
    end

    // Reference model: unbounded per-window edge totals, clamped on compare.
    // A pin change becomes countable two clocks after it is sampled.
    int unsigned    m_per, m_pos;
    int unsigned    m_cnt [NCH];
    int unsigned    e_res [NCH];
    logic           e_rv;
    logic [NCH-1:0] p1, p2, p3;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_per = 1200;
            m_pos = 0;
            e_rv  = 1'b0;
            p1 = '0; p2 = '0; p3 = '0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0;
                e_res[c] = 0;
            end
        end else begin
            if (ld && per != 0) begin
                m_per = per;
                m_pos = 0;
                e_rv  = 1'b0;
                for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (be ? (p2[c] != p3[c]) : (p2[c] && !p3[c]))
                        m_cnt[c]++;
                end
                if (m_pos == m_per - 1) begin
                    for (int c = 0; c < NCH; c++) begin
                        e_res[c] = m_cnt[c];
                        m_cnt[c] = 0;
                    end
                    m_pos = 0;
                    e_rv  = 1'b1;
                end else begin
                    m_pos++;
                    e_rv = 1'b0;
                end
            end
            p3 = p2;
            p2 = p1;
            p1 = sig;
        end
    end

    logic [63:0] x0;
    logic [3:0]  o0;
    logic [7:0]  x4;
    logic [1:0]  o4;

    always @(negedge clk) begin
        if (reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                x0[c*16 +: 16] = (e_res[c] > 65535) ? 16'hFFFF : e_res[c][15:0];
                o0[c] = (e_res[c] > 65535);
            end
            for (int c = 0; c < 2; c++) begin
                x4[c*4 +: 4] = (e_res[c] > 15) ? 4'hF : e_res[c][3:0];
                o4[c] = (e_res[c] > 15);
            end
            check("model_rv0", bus0.result_valid, e_rv);
            check("model_rv4", bus4.result_valid, e_rv);
            check("model_flat0", bus0.count_flat, x0);
            check("model_ovf0", bus0.overflow, o0);
            check("model_flat4", bus4.count_flat, x4);
            check("model_ovf4", bus4.overflow, o4);
        end
    end

    task automatic wait_rv(input int lim, output int k);
        k = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (bus0.result_valid) begin
                k = i;
                break;
            end
        end
        if (k == 0) check("rv_timeout", k, lim);
    endtask

    typedef struct {
        int per;
        int half;
        bit be;
        int e0;
        int e4;
        bit o4;
    } vec_t;

    vec_t vt [9];
    int   k;
    bit   found;

    task automatic reset_values(input string tag);
        check({tag, "_flat0"}, bus0.count_flat, 64'h0);
        check({tag, "_ovf0"}, bus0.overflow, 4'h0);
        check({tag, "_flat4"}, bus4.count_flat, 8'h0);
        check({tag, "_rv"}, bus0.result_valid, 1'b0);
        check({tag, "_seg"}, bus0.segments, 7'h3F);
        check({tag, "_digit"}, bus0.digit, 1'b0);
    endtask

    initial begin
        vt[0] = '{100, 5,  1'b0, 10, 10, 1'b0};
        vt[1] = '{100, 5,  1'b1, 20, 15, 1'b1};
        vt[2] = '{60,  3,  1'b0, 10, 10, 1'b0};
        vt[3] = '{60,  2,  1'b0, 15, 15, 1'b0};
        vt[4] = '{64,  4,  1'b1, 16, 15, 1'b1};
        vt[5] = '{100, 2,  1'b0, 25, 15, 1'b1};
        vt[6] = '{100, 10, 1'b0, 5,  5,  1'b0};
        vt[7] = '{48,  2,  1'b1, 24, 15, 1'b1};
        vt[8] = '{30,  15, 1'b0, 1,  1,  1'b0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        reset_values("reset");
        wait_rv(1300, k);
        check("default_period", k, 1200);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            per  = PW'(vt[i].per);
            ld   = 1'b1;
            half = vt[i].half;
            be   = vt[i].be;
            mode = 1;
            @(negedge clk);
            ld = 1'b0;
            wait_rv(5000, k);
            wait_rv(5000, k);
            check($sformatf("vec%0d_interval", i), k, vt[i].per);
            check($sformatf("vec%0d_ch0", i), bus0.count_flat[15:0], vt[i].e0);
            check($sformatf("vec%0d_ch1", i), bus0.count_flat[31:16], 16'h0);
            check($sformatf("vec%0d_sat", i), bus4.count_flat[3:0], vt[i].e4);
            check($sformatf("vec%0d_ovf", i), bus4.overflow[0], vt[i].o4);
        end

        mode = 0;
        be = 1'b0;
        @(negedge clk);
        per = 12'd100;
        ld  = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_rv(300, k);
        repeat (29) @(negedge clk);
        per = 12'd50;
        ld  = 1'b1;
        k   = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i == 1) ld = 1'b0;
            if (bus0.result_valid) begin
                k = i;
                break;
            end
        end
        check("abort_latency", k, 51);

        repeat (10) @(negedge clk);
        per = 12'd0;
        ld  = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_rv(200, k);
        check("zero_load_ignored", k, 39);
        wait_rv(200, k);
        check("zero_load_period", k, 50);

        per = 12'd20;
        ld  = 1'b1;
        repeat (5) @(negedge clk);
        ld = 1'b0;
        wait_rv(200, k);
        check("held_load", k, 20);

        mode = 2;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            ld  = ($urandom_range(0, 199) == 0);
            per = PW'($urandom_range(0, 250));
            if ($urandom_range(0, 99) == 0) be = ~be;
        end
        ld   = 1'b0;
        mode = 0;
        be   = 1'b0;

        @(negedge clk);
        per = 12'd400;
        ld  = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        wait_rv(600, k);
        burst = 334;
        mode  = 3;
        wait_rv(600, k);
        check("a7_count", bus0.count_flat[31:16], 16'h00A7);
        mode = 0;
        sel  = 3'd1;
        repeat (2) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus0.digit == 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("digit0_seen", found, 1'b1);
        check("seg_digit0", bus0.segments, 7'b0000111);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus0.digit == 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("digit1_seen", found, 1'b1);
        check("seg_digit1", bus0.segments, 7'b1110111);
        sel = 3'd4;
        repeat (2) @(negedge clk);
        check("seg_blank", bus0.segments, 7'b0000000);

        repeat (50) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        reset_values("midreset");
        sel = 3'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wait_rv(1300, k);
        check("post_reset_period", k, 1200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
